// File: rtl/bicubic_tile_scheduler_if.sv
// Handshake bundle between the bicubic tile scheduler, the window fetch stage,
// the upsample engine and the output writer. master = scheduler side.
interface bicubic_tile_scheduler_if #(
  parameter int XW = 12,
  parameter int YW = 12
);
  logic          frame_start;
  logic          busy;
  logic          frame_done;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          fetch_valid;
  logic          fetch_ready;
  logic          bf_req_valid;
  logic          bcci_req_ready;
  logic          bcci_rsp_valid;
  logic          bf_rsp_ready;
  logic          out_valid;
  logic          out_ready;
  logic [XW+1:0] out_x;
  logic [YW+1:0] out_y;
  logic          out_last;

  modport master (
    input  frame_start, fetch_valid, bcci_req_ready, bcci_rsp_valid, out_ready,
    output busy, frame_done, win_x, win_y, fetch_ready, bf_req_valid,
           bf_rsp_ready, out_valid, out_x, out_y, out_last
  );

  modport slave (
    output frame_start, fetch_valid, bcci_req_ready, bcci_rsp_valid, out_ready,
    input  busy, frame_done, win_x, win_y, fetch_ready, bf_req_valid,
           bf_rsp_ready, out_valid, out_x, out_y, out_last
  );
endinterface

// File: rtl/bicubic_tile_scheduler.sv
// Raster-order tile sequencer for the 4x bicubic upsample engine: one window
// request per tile, four tagged response beats. BICUBIC_SCHED_PERF_EN adds stall/tile counters.
module bicubic_tile_scheduler #(
  parameter int SRC_W = 960,
  parameter int SRC_H = 540,
  parameter int XW    = 12,
  parameter int YW    = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bicubic_tile_scheduler_if.master bus
`ifdef BICUBIC_SCHED_PERF_EN
  ,
  output logic [15:0]             stall_cnt,
  output logic [XW+YW-1:0]        tile_cnt
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [XW-1:0] COL_MAX = XW'(SRC_W - 1);
  localparam logic [YW-1:0] ROW_MAX = YW'(SRC_H - 1);

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic [1:0]    beat_q, beat_d;

  logic in_idle, in_issue, in_collect;
  logic req_hsk, rsp_hsk, last_tile, frame_accept;

  assign in_idle    = (state_q == S_IDLE);
  assign in_issue   = (state_q == S_ISSUE);
  assign in_collect = (state_q == S_COLLECT);

  // The engine only raises req_ready once it may respond, so rsp_ready is
  // held high throughout ISSUE to keep the two handshakes from deadlocking.
  assign bus.fetch_ready  = in_issue & bus.bcci_req_ready;
  assign bus.bf_req_valid = in_issue & bus.fetch_valid;
  assign bus.bf_rsp_ready = in_issue | (in_collect & bus.out_ready);
  assign bus.out_valid    = in_collect & bus.bcci_rsp_valid;

  assign req_hsk      = bus.bf_req_valid & bus.bcci_req_ready;
  assign rsp_hsk      = bus.out_valid & bus.out_ready;
  assign last_tile    = (col_q == COL_MAX) && (row_q == ROW_MAX);
  assign frame_accept = in_idle & bus.frame_start;

  assign bus.busy       = !in_idle;
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.win_x      = col_q;
  assign bus.win_y      = row_q;
  assign bus.out_x      = {col_q, 2'b00};
  assign bus.out_y      = {row_q, beat_q};
  assign bus.out_last   = in_collect && (beat_q == 2'd3) && last_tile;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (bus.frame_start) begin
          state_d = S_ISSUE;
          col_d   = '0;
          row_d   = '0;
          beat_d  = '0;
        end
      end
      S_ISSUE: begin
        if (req_hsk) begin
          state_d = S_COLLECT;
          beat_d  = '0;
        end
      end
      S_COLLECT: begin
        if (rsp_hsk) begin
          if (beat_q != 2'd3) begin
            beat_d = beat_q + 2'd1;
          end else begin
            beat_d = '0;
            if (last_tile) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ISSUE;
              if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = row_q + YW'(1);
              end else begin
                col_d = col_q + XW'(1);
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      beat_q  <= beat_d;
    end
  end

`ifdef BICUBIC_SCHED_PERF_EN
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic [XW+YW-1:0] tile_cnt_q, tile_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    tile_cnt_d  = tile_cnt_q;
    if (frame_accept) begin
      stall_cnt_d = '0;
      tile_cnt_d  = '0;
    end else begin
      if (in_collect && bus.bcci_rsp_valid && !bus.out_ready && (stall_cnt_q != 16'hFFFF))
        stall_cnt_d = stall_cnt_q + 16'd1;
      if (rsp_hsk && (beat_q == 2'd3))
        tile_cnt_d = tile_cnt_q + (XW+YW)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      tile_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      tile_cnt_q  <= tile_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign tile_cnt  = tile_cnt_q;
`endif

endmodule

// File: tb/tb_bicubic_tile_scheduler.sv
// Directed bench for bicubic_tile_scheduler on a 3x2-tile frame.
module tb_bicubic_tile_scheduler;
  localparam int SRC_W = 3;
  localparam int SRC_H = 2;
  localparam int XW    = 12;
  localparam int YW    = 12;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bicubic_tile_scheduler_if #(.XW(XW), .YW(YW)) bus ();

`ifdef BICUBIC_SCHED_PERF_EN
  logic [15:0]      stall_cnt;
  logic [XW+YW-1:0] tile_cnt;
`endif

  bicubic_tile_scheduler #(.SRC_W(SRC_W), .SRC_H(SRC_H), .XW(XW), .YW(YW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BICUBIC_SCHED_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .tile_cnt  (tile_cnt)
`endif
  );

  logic [6:0] flags;
  assign flags = {bus.busy, bus.frame_done, bus.fetch_ready, bus.bf_req_valid,
                  bus.out_valid, bus.out_last, bus.bf_rsp_ready};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.frame_start    = 1'b0;
    bus.fetch_valid    = 1'b0;
    bus.bcci_req_ready = 1'b1;
    bus.bcci_rsp_valid = 1'b0;
    bus.out_ready      = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic issue_tile();
    bus.fetch_valid = 1'b1;
    tick();
    bus.fetch_valid = 1'b0;
  endtask

  task automatic send_beat();
    bus.bcci_rsp_valid = 1'b1;
    tick();
    bus.bcci_rsp_valid = 1'b0;
  endtask

  task automatic run_tile();
    issue_tile();
    repeat (4) send_beat();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.frame_start    = 1'b1;
    bus.fetch_valid    = 1'b1;
    bus.bcci_rsp_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (flags !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected %b", flags, 7'b0);
    end
    checks++;
    if ({bus.win_x, bus.win_y, bus.out_x, bus.out_y} !== '0) begin
      errors++;
      $display("FAIL reset_coords: got x=%0d y=%0d ox=%0d oy=%0d expected all 0",
               bus.win_x, bus.win_y, bus.out_x, bus.out_y);
    end
    idle_inputs();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    int req_n = 0;
    int rsp_n = 0;
    int pending = 0;
    int cyc = 0;
    int ex, ey;
    do_reset();
    start_frame();
    bus.fetch_valid = 1'b1;
    while (rsp_n < 24 && cyc < 400) begin
      bus.bcci_rsp_valid = (pending > 0);
      #1;
      if (bus.bf_req_valid && bus.bcci_req_ready) begin
        checks++;
        if (bus.win_x !== XW'(req_n % SRC_W) || bus.win_y !== YW'(req_n / SRC_W) || pending != 0) begin
          errors++;
          $display("FAIL req_tile%0d: got win=(%0d,%0d) pending=%0d expected (%0d,%0d) pending=0",
                   req_n, bus.win_x, bus.win_y, pending, req_n % SRC_W, req_n / SRC_W);
        end
        req_n++;
        pending = 4;
      end
      if (bus.out_valid && bus.out_ready) begin
        ex = 4 * ((rsp_n / 4) % SRC_W);
        ey = 4 * ((rsp_n / 4) / SRC_W) + (rsp_n % 4);
        checks++;
        if (bus.out_x !== (XW+2)'(ex) || bus.out_y !== (YW+2)'(ey) || bus.out_last !== (rsp_n == 23)) begin
          errors++;
          $display("FAIL beat%0d: got x=%0d y=%0d last=%b expected x=%0d y=%0d last=%b",
                   rsp_n, bus.out_x, bus.out_y, bus.out_last, ex, ey, rsp_n == 23);
        end
        rsp_n++;
        pending--;
      end
      tick();
      cyc++;
    end
    bus.fetch_valid    = 1'b0;
    bus.bcci_rsp_valid = 1'b0;
    checks++;
    if (req_n != 6 || rsp_n != 24) begin
      errors++;
      $display("FAIL frame_counts: got req=%0d rsp=%0d expected req=6 rsp=24", req_n, rsp_n);
    end
    #1;
    checks++;
    if (bus.frame_done !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_pulse: got done=%b busy=%b expected done=1 busy=1",
               bus.frame_done, bus.busy);
    end
    tick();
    checks++;
    if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got done=%b busy=%b expected done=0 busy=0",
               bus.frame_done, bus.busy);
    end
`ifdef BICUBIC_SCHED_PERF_EN
    checks++;
    if (tile_cnt !== (XW+YW)'(6) || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL perf_frame: got tiles=%0d stalls=%0d expected tiles=6 stalls=0", tile_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_out_stall();
    do_reset();
    start_frame();
    issue_tile();
    send_beat();
    send_beat();
    bus.bcci_rsp_valid = 1'b1;
    bus.out_ready      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.bf_rsp_ready !== 1'b0 || bus.out_y !== (YW+2)'(2)) begin
        errors++;
        $display("FAIL stall_cyc%0d: got valid=%b rsp_ready=%b y=%0d expected valid=1 rsp_ready=0 y=2",
                 i, bus.out_valid, bus.bf_rsp_ready, bus.out_y);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.bf_rsp_ready !== 1'b1 || bus.out_y !== (YW+2)'(2)) begin
      errors++;
      $display("FAIL stall_release: got valid=%b rsp_ready=%b y=%0d expected valid=1 rsp_ready=1 y=2",
               bus.out_valid, bus.bf_rsp_ready, bus.out_y);
    end
`ifdef BICUBIC_SCHED_PERF_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected 5", stall_cnt);
    end
`endif
    tick();
    #1;
    checks++;
    if (bus.out_y !== (YW+2)'(3) || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL beat3_tile0: got y=%0d last=%b expected y=3 last=0", bus.out_y, bus.out_last);
    end
    tick();
    bus.bcci_rsp_valid = 1'b0;
  endtask

  task automatic test_fetch_stall();
    bus.fetch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.bf_req_valid !== 1'b0 || bus.fetch_ready !== 1'b1 || bus.busy !== 1'b1 ||
          bus.out_valid !== 1'b0 || bus.win_x !== XW'(1) || bus.win_y !== YW'(0)) begin
        errors++;
        $display("FAIL fetch_stall%0d: got req_v=%b f_rdy=%b busy=%b win=(%0d,%0d) expected 0,1,1,(1,0)",
                 i, bus.bf_req_valid, bus.fetch_ready, bus.busy, bus.win_x, bus.win_y);
      end
      tick();
    end
    bus.fetch_valid = 1'b1;
    #1;
    checks++;
    if (bus.bf_req_valid !== 1'b1 || bus.win_x !== XW'(1)) begin
      errors++;
      $display("FAIL fetch_resume: got req_v=%b win_x=%0d expected req_v=1 win_x=1",
               bus.bf_req_valid, bus.win_x);
    end
    tick();
    bus.fetch_valid = 1'b0;
  endtask

  task automatic test_ignored_inputs();
    bus.frame_start    = 1'b1;
    bus.bcci_rsp_valid = 1'b1;
    tick();
    bus.frame_start    = 1'b0;
    bus.bcci_rsp_valid = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.win_x !== XW'(1) || bus.out_y !== (YW+2)'(1)) begin
      errors++;
      $display("FAIL start_midframe: got busy=%b win_x=%0d y=%0d expected busy=1 win_x=1 y=1",
               bus.busy, bus.win_x, bus.out_y);
    end
    repeat (3) send_beat();
    bus.bcci_rsp_valid = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.bf_rsp_ready !== 1'b1 || bus.win_x !== XW'(2)) begin
      errors++;
      $display("FAIL rsp_in_issue: got out_valid=%b rsp_ready=%b win_x=%0d expected 0,1,2",
               bus.out_valid, bus.bf_rsp_ready, bus.win_x);
    end
    tick();
    bus.bcci_rsp_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.win_x !== XW'(2) || bus.win_y !== YW'(0)) begin
      errors++;
      $display("FAIL issue_hold: got out_valid=%b win=(%0d,%0d) expected 0,(2,0)",
               bus.out_valid, bus.win_x, bus.win_y);
    end
    run_tile();
    run_tile();
    run_tile();
    issue_tile();
    repeat (3) send_beat();
    bus.bcci_rsp_valid = 1'b1;
    #1;
    checks++;
    if (bus.out_last !== 1'b1 || bus.out_x !== (XW+2)'(8) || bus.out_y !== (YW+2)'(7)) begin
      errors++;
      $display("FAIL final_beat: got last=%b x=%0d y=%0d expected last=1 x=8 y=7",
               bus.out_last, bus.out_x, bus.out_y);
    end
    tick();
    bus.bcci_rsp_valid = 1'b0;
    bus.frame_start    = 1'b1;
    #1;
    checks++;
    if (bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL done_after_stall_frame: got %b expected 1", bus.frame_done);
    end
    tick();
    bus.frame_start = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.bf_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got busy=%b req_v=%b expected busy=0 req_v=0",
               bus.busy, bus.bf_req_valid);
    end
`ifdef BICUBIC_SCHED_PERF_EN
    checks++;
    if (tile_cnt !== (XW+YW)'(6) || stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL perf_hold: got tiles=%0d stalls=%0d expected tiles=6 stalls=5", tile_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    do_reset();
    start_frame();
    run_tile();
    run_tile();
    issue_tile();
    send_beat();
    bus.bcci_rsp_valid = 1'b1;
    bus.fetch_valid    = 1'b1;
    #1;
    checks++;
    if (bus.out_x !== (XW+2)'(8) || bus.out_y !== (YW+2)'(1) || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pos: got x=%0d y=%0d valid=%b expected x=8 y=1 valid=1",
               bus.out_x, bus.out_y, bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (flags !== 7'b0 || {bus.win_x, bus.win_y, bus.out_x, bus.out_y} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got flags=%b win=(%0d,%0d) out=(%0d,%0d) expected all 0",
               flags, bus.win_x, bus.win_y, bus.out_x, bus.out_y);
    end
`ifdef BICUBIC_SCHED_PERF_EN
    checks++;
    if (tile_cnt !== '0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL perf_reset: got tiles=%0d stalls=%0d expected 0,0", tile_cnt, stall_cnt);
    end
`endif
    tick();
    idle_inputs();
    #2 rst_n = 1'b1;
    tick();
    start_frame();
    bus.fetch_valid = 1'b1;
    #1;
    checks++;
    if (bus.win_x !== XW'(0) || bus.win_y !== YW'(0) || bus.bf_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_tile: got win=(%0d,%0d) req_v=%b expected (0,0) req_v=1",
               bus.win_x, bus.win_y, bus.bf_req_valid);
    end
    tick();
    bus.fetch_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_out_stall();
    test_fetch_stall();
    test_ignored_inputs();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
